pwm_generator: RTL and testbench
================================

# pwm_generator

Fixed-frequency PWM source with a duty cycle adjustable in discrete steps by two pushbutton-style request inputs. Each rising edge on `increase_duty` or `decrease_duty` moves the duty cycle one step up or down, saturating at configured limits. It sits between user or control logic and a single PWM output pin, for example an LED or motor driver, in a single clock domain.

## Interface
- `PERIOD`, default 10: PWM period in clock cycles; must be ≥ 2.
- `DUTY_INIT`, default 5: duty, in high cycles per period, loaded at reset (50%).
- `DUTY_STEP`, default 1: change in high cycles per request (10% at defaults).
- `DUTY_MIN`, default 1: lower duty limit (10%).
- `DUTY_MAX`, default 9: upper duty limit (90%).
- Parameter constraint: `DUTY_MIN` ≤ `DUTY_INIT` ≤ `DUTY_MAX` ≤ `PERIOD`.
- Counter/duty width: $clog2(`PERIOD`+1) bits.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `increase_duty`, input, 1: step-up request; level input, edge-detected.
- `decrease_duty`, input, 1: step-down request; level input, edge-detected.
- `pwm_out`, output, 1: registered PWM waveform.

## Operation
- Both request inputs pass through a 2-flop synchronizer, then a rising-edge detector. One request is produced per 0→1 transition. A level held high produces exactly one step.
- Duty register `duty`:
  - Increase request only: `duty` = min(`duty` + `DUTY_STEP`, `DUTY_MAX`).
  - Decrease request only: `duty` = max(`duty` − `DUTY_STEP`, `DUTY_MIN`).
  - Both requests in the same cycle, or neither: `duty` unchanged.
  - Saturation is computed without wrap-around; the intermediate sum uses one extra bit.
- Period counter `cnt` counts 0..`PERIOD`−1 and then wraps to 0. It is free-running.
- Active duty `duty_act` loads from `duty` only when `cnt` = `PERIOD`−1, so it takes effect at the next period start. This keeps periods glitch-free: no period ever mixes two duty values.
- `pwm_out` is registered as (`cnt` < `duty_act`). Each period therefore has exactly `duty_act` high cycles followed by `PERIOD`−`duty_act` low cycles.

## Timing
- Reset (asynchronous assert; release takes effect on the next clock):
  - `cnt` = 0, `duty` = `duty_act` = `DUTY_INIT`.
  - Synchronizer and edge flops = 0.
  - `pwm_out` = 0.
- After reset release, `pwm_out` goes high on the first rising clock edge, since `cnt` = 0 < `DUTY_INIT`. It then follows the pattern with 1-cycle register lag behind `cnt`.
- Request latency: the input is sampled high at clock edge k; `duty` updates at edge k+2 (two synchronizer stages, then edge detect plus update in the same cycle as stage-2 output rising).
- A 1-cycle input pulse, set after one edge and cleared after the next, is sufficient.
- Back-to-back requests require the input to return low for at least one sampled cycle between pulses.
- A new duty reaches `pwm_out` at the first period boundary after `duty` updates, i.e. within at most `PERIOD`+1 cycles.
- Reset mid-period aborts the current period immediately: `pwm_out` = 0 and the duty returns to `DUTY_INIT`.

## Test plan
- Reset, then run 3 periods with no requests → every period is 5 high / 5 low cycles (50%); `pwm_out` = 0 during reset.
- One 1-cycle `increase_duty` pulse → the first full period after the boundary is 6/4. Three more pulses spaced 20 cycles apart → 9/1 (90%). A fifth pulse → remains 9/1 (saturated).
- From 9/1, two `decrease_duty` pulses → 8/2, then 7/3. Then eight more pulses → saturates at 1/9 and stays there.
- `increase_duty` held high for 50 cycles → exactly one step (5→6).
- `increase_duty` and `decrease_duty` pulsed in the same cycle → duty unchanged at 5/5.
- Request landing mid-period (`cnt` = 3) → the current period keeps the old duty, with no extra or missing high cycle. Assert `rst` mid-period → `pwm_out` = 0 at once; after release the output is 5/5 again.

Source files
------------

// File: rtl/pwm_generator.sv
// Fixed-frequency PWM with duty adjustable in steps by two edge-detected request inputs.
// Duty changes are deferred to the next period boundary so no period mixes two duty values.
module pwm_generator #(
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int DUTY_STEP = 1,
  parameter int DUTY_MIN  = 1,
  parameter int DUTY_MAX  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic pwm_out
);

  localparam int W = $clog2(PERIOD + 1);

  localparam logic [W-1:0] CNT_LAST   = W'(PERIOD - 1);
  localparam logic [W-1:0] INIT_VAL   = W'(DUTY_INIT);
  localparam logic [W-1:0] MIN_VAL    = W'(DUTY_MIN);
  localparam logic [W-1:0] MAX_VAL    = W'(DUTY_MAX);
  localparam logic [W-1:0] STEP_VAL   = W'(DUTY_STEP);
  localparam logic [W:0]   MAX_EXT    = (W+1)'(DUTY_MAX);
  localparam logic [W:0]   DEC_FLOOR  = (W+1)'(DUTY_MIN + DUTY_STEP);

  logic [1:0]   inc_sync;
  logic [1:0]   dec_sync;
  logic         inc_prev;
  logic         dec_prev;
  logic         inc_req;
  logic         dec_req;
  logic [W-1:0] cnt;
  logic [W-1:0] duty;
  logic [W-1:0] duty_act;
  logic [W-1:0] duty_next;
  logic [W:0]   duty_up;

  assign inc_req = inc_sync[1] & ~inc_prev;
  assign dec_req = dec_sync[1] & ~dec_prev;

  // Saturating step; the extra top bit keeps the sum from wrapping before the limit test.
  always_comb begin
    duty_next = duty;
    duty_up   = {1'b0, duty} + {1'b0, STEP_VAL};
    if (inc_req && !dec_req) begin
      duty_next = (duty_up > MAX_EXT) ? MAX_VAL : duty_up[W-1:0];
    end else if (dec_req && !inc_req) begin
      duty_next = ({1'b0, duty} < DEC_FLOOR) ? MIN_VAL : (duty - STEP_VAL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sync <= 2'b00;
      dec_sync <= 2'b00;
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
      duty     <= INIT_VAL;
    end else begin
      inc_sync <= {inc_sync[0], increase_duty};
      dec_sync <= {dec_sync[0], decrease_duty};
      inc_prev <= inc_sync[1];
      dec_prev <= dec_sync[1];
      duty     <= duty_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty_act <= INIT_VAL;
      pwm_out  <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty_act);
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        duty_act <= duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: each period's expected high count is queued when the
// period starts (before any request it carries) and compared against the sampled waveform.
module tb_pwm_generator;

  localparam int PERIOD = 10;
  localparam int D_INIT = 5;
  localparam int D_MIN  = 1;
  localparam int D_MAX  = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic increase_duty = 1'b0;
  logic decrease_duty = 1'b0;
  logic pwm_out;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int model_duty = D_INIT;
  int exp_q[$];

  pwm_generator #(
    .PERIOD(PERIOD), .DUTY_INIT(D_INIT), .DUTY_STEP(1), .DUTY_MIN(D_MIN), .DUTY_MAX(D_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; edge 1 is the first rising edge out of reset.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    #1;
    checks++;
    assert (pwm_out === 1'b0) else begin
      failures++;
      $error("FAIL %s: pwm_out during reset observed=%b expected=0", tag, pwm_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    assert (pwm_out === 1'b0) else begin
      failures++;
      $error("FAIL %s_hold: pwm_out held in reset observed=%b expected=0", tag, pwm_out);
    end
    rst = 1'b0;
    model_duty = D_INIT;
  endtask

  // Samples one full period; optionally starts a request after the sample where cnt is 3.
  task automatic check_period(input string tag, input bit inc, input bit dec, input bit keep);
    logic [PERIOD-1:0] got;
    logic [PERIOD-1:0] want;
    int guard;
    int exp_hi;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((edge_n % PERIOD) != 1 && guard < 4 * PERIOD);
    if (guard >= 4 * PERIOD) begin
      checks++;
      failures++;
      $display("FAIL %s_align: no period start within %0d cycles", tag, guard);
      return;
    end
    exp_q.push_back(model_duty);
    if (inc && !dec) model_duty = (model_duty + 1 > D_MAX) ? D_MAX : model_duty + 1;
    if (dec && !inc) model_duty = (model_duty - 1 < D_MIN) ? D_MIN : model_duty - 1;
    for (int i = 0; i < PERIOD; i++) begin
      got[i] = pwm_out;
      if (i == 3) begin
        if (inc) increase_duty = 1'b1;
        if (dec) decrease_duty = 1'b1;
      end
      if (i == 4 && !keep) begin
        if (inc) increase_duty = 1'b0;
        if (dec) decrease_duty = 1'b0;
      end
      if (i != PERIOD - 1) @(negedge clk);
    end
    exp_hi = exp_q.pop_front();
    for (int i = 0; i < PERIOD; i++) want[i] = (i < exp_hi);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: period pattern observed=%b expected=%b (high=%0d)", tag, got, want, exp_hi);
    end
  endtask

  initial begin
    do_reset("reset0");
    for (int p = 0; p < 3; p++) check_period("idle50", 1'b0, 1'b0, 1'b0);

    // Five increase pulses, 20 cycles apart: 5 -> 9 then saturated.
    for (int k = 0; k < 5; k++) begin
      check_period("inc_pulse", 1'b1, 1'b0, 1'b0);
      check_period("inc_after", 1'b0, 1'b0, 1'b0);
    end

    // Ten decrease pulses: 9 -> 8 -> 7 ... saturates at 1.
    for (int k = 0; k < 10; k++) begin
      check_period("dec_pulse", 1'b0, 1'b1, 1'b0);
      check_period("dec_after", 1'b0, 1'b0, 1'b0);
    end
    check_period("dec_sat", 1'b0, 1'b0, 1'b0);

    // Held level: exactly one step, release gives none.
    do_reset("reset_hold");
    check_period("hold_start", 1'b1, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) check_period("hold_high", 1'b0, 1'b0, 1'b0);
    increase_duty = 1'b0;
    check_period("hold_release", 1'b0, 1'b0, 1'b0);
    check_period("hold_after", 1'b0, 1'b0, 1'b0);

    // Simultaneous requests cancel.
    do_reset("reset_both");
    check_period("both_pulse", 1'b1, 1'b1, 1'b0);
    check_period("both_after", 1'b0, 1'b0, 1'b0);
    check_period("both_after2", 1'b0, 1'b0, 1'b0);

    // Move to 6/4, then reset mid-period.
    check_period("pre_abort", 1'b1, 1'b0, 1'b0);
    check_period("pre_abort6", 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    assert (pwm_out === 1'b1) else begin
      failures++;
      $error("FAIL abort_pre: pwm_out mid-period observed=%b expected=1", pwm_out);
    end
    do_reset("abort");
    for (int p = 0; p < 2; p++) check_period("post_abort", 1'b0, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: leftover entries observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
